// File: rtl/bram_pixel_to_axis_if.sv
// AXI4-Stream bundle carrying packed 9-direction pixels.
// master drives tvalid/tdata/tstrb/tlast; slave drives tready.
interface bram_pixel_to_axis_if #(
  parameter int TDATA_W = 144
);
  logic               tvalid;
  logic [TDATA_W-1:0] tdata;
  logic [TDATA_W/8-1:0] tstrb;
  logic               tlast;
  logic               tready;

  modport master (
    output tvalid, tdata, tstrb, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tlast,
    output tready
  );
endinterface

// File: rtl/bram_pixel_to_axis.sv
// Streams one frame of DEPTH pixels from BRAM onto AXI4-Stream.
// Ports: start/busy/done control, rd_en/read_addr + 9 dir inputs, m00_axis.
module bram_pixel_to_axis #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_aresetn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0]    n0,
  input  logic [DATA_WIDTH-1:0]    null0,
  input  logic [DATA_WIDTH-1:0]    ne0,
  input  logic [DATA_WIDTH-1:0]    e0,
  input  logic [DATA_WIDTH-1:0]    se0,
  input  logic [DATA_WIDTH-1:0]    s0,
  input  logic [DATA_WIDTH-1:0]    sw0,
  input  logic [DATA_WIDTH-1:0]    w0,
  input  logic [DATA_WIDTH-1:0]    nw0,
  bram_pixel_to_axis_if.master     m00_axis
);

  localparam int PIX_W  = 9 * DATA_WIDTH;
  localparam int BEAT_W = 12;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_A =
    ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] LAST_B = BEAT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FINISH
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic                     infl_q;
  logic [PIX_W-1:0]         mem_q [3];
  logic [1:0]               wr_q, rd_q;
  logic [1:0]               cnt_q, cnt_d;

  logic             push;
  logic             pop;
  logic             room;
  logic             tvalid;
  logic [PIX_W-1:0] pix;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pix = {nw0, w0, sw0, s0, se0, e0, ne0, null0, n0};

  // BRAM data lands the cycle after the strobe, so the
  // in-flight flag doubles as the FIFO write enable.
  assign push   = infl_q;
  assign tvalid = (cnt_q != 2'd0);
  assign pop    = tvalid && m00_axis.tready;

  // Reserve a slot for the outstanding read; a pop in the
  // same cycle is deliberately not credited.
  assign room = (3'(cnt_q) + 3'(infl_q)) < 3'd3;

  assign read_addr       = addr_q;
  assign m00_axis.tvalid = tvalid;
  assign m00_axis.tdata  = mem_q[rd_q];
  assign m00_axis.tstrb  = tvalid ? '1 : '0;
  assign m00_axis.tlast  = tvalid && (beat_q == LAST_B);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
    if (pop) beat_d = beat_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          addr_d  = '0;
          beat_d  = '0;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (room) begin
          rd_en = 1'b1;
          if (addr_q == LAST_A) state_d = DRAIN;
          else                  addr_d  = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && beat_q == LAST_B) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      infl_q  <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      infl_q  <= rd_en;
      cnt_q   <= cnt_d;
      if (push) begin
        mem_q[wr_q] <= pix;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
    end
  end

endmodule

// File: tb/tb_bram_pixel_to_axis.sv
// Directed bench for bram_pixel_to_axis.
// BRAM model returns k*16+d; scoreboard checks every beat.
module tb_bram_pixel_to_axis;
  localparam int DEPTH = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, rd_en;
  logic [11:0] read_addr;
  logic [15:0] n0, null0, ne0, e0, se0, s0, sw0, w0, nw0;

  bram_pixel_to_axis_if #(.TDATA_W(144)) ax ();

  bram_pixel_to_axis dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .rd_en           (rd_en),
    .read_addr       (read_addr),
    .n0              (n0),
    .null0           (null0),
    .ne0             (ne0),
    .e0              (e0),
    .se0             (se0),
    .s0              (s0),
    .sw0             (sw0),
    .w0              (w0),
    .nw0             (nw0),
    .m00_axis        (ax.master)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [143:0] got,
                     input logic [143:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] pk(input int k);
    logic [143:0] p;
    for (int d = 0; d < 9; d++) p[d*16 +: 16] = 16'(k * 16 + d);
    return p;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      n0    <= 16'(read_addr * 16 + 0);
      null0 <= 16'(read_addr * 16 + 1);
      ne0   <= 16'(read_addr * 16 + 2);
      e0    <= 16'(read_addr * 16 + 3);
      se0   <= 16'(read_addr * 16 + 4);
      s0    <= 16'(read_addr * 16 + 5);
      sw0   <= 16'(read_addr * 16 + 6);
      w0    <= 16'(read_addr * 16 + 7);
      nw0   <= 16'(read_addr * 16 + 8);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_k, exp_a, rd_tot, tl_cnt, dn_cnt;
  int rd_cyc, tv_cyc, hs0_cyc, hsl_cyc, dn_cyc;
  int st_rd;
  bit stalling;
  bit busy_dn;
  bit prv_stall;
  logic [143:0] prv_data;
  logic         prv_last;

  task automatic reset_sb();
    exp_k = 0; exp_a = 0; rd_tot = 0; tl_cnt = 0; dn_cnt = 0;
    rd_cyc = -1; tv_cyc = -1; hs0_cyc = -1; hsl_cyc = -1;
    dn_cyc = -1; st_rd = 0; stalling = 0; busy_dn = 1;
    prv_stall = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prv_stall) begin
        chk("hold_tvalid", ax.tvalid, 1'b1);
        chk("hold_tdata", ax.tdata, prv_data);
        chk("hold_tlast", ax.tlast, prv_last);
      end
      prv_stall = ax.tvalid && !ax.tready;
      prv_data  = ax.tdata;
      prv_last  = ax.tlast;
      if (rd_en) begin
        chk("rd_addr", read_addr, exp_a);
        exp_a++;
        rd_tot++;
        if (rd_cyc < 0) rd_cyc = cyc;
        if (stalling) st_rd++;
      end
      if (ax.tvalid && tv_cyc < 0) tv_cyc = cyc;
      if (ax.tvalid && ax.tready) begin
        chk("tdata", ax.tdata, pk(exp_k));
        chk("tlast", ax.tlast, exp_k == DEPTH - 1);
        chk("tstrb", ax.tstrb, 18'h3ffff);
        if (ax.tlast) tl_cnt++;
        if (hs0_cyc < 0) hs0_cyc = cyc;
        hsl_cyc = cyc;
        exp_k++;
      end
      if (done) begin
        dn_cnt++;
        dn_cyc  = cyc;
        busy_dn = busy;
      end
    end
  end

  // mode 0: tready=1, mode 1: random 50%
  task automatic run_frame(input int mode, input int stall_at,
                           input int start_at, input int rst_at);
    int  n;
    int  left;
    bit  st_done;
    bit  sd_done;
    reset_sb();
    left = 0; st_done = 0; sd_done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    ax.tready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (dn_cnt == 0 && n < 20000) begin
      if (rst_at >= 0 && exp_k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tvalid", ax.tvalid, 1'b0);
        chk("rst_mid_rd_en", rd_en, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_tdata", ax.tdata, 144'd0);
        return;
      end
      if (stall_at >= 0 && !st_done && exp_k == stall_at) begin
        left = 10;
        st_done = 1;
      end
      if (left > 0) begin
        ax.tready = 1'b0;
        stalling = 1;
        left--;
      end else begin
        stalling = 0;
        ax.tready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      end
      start = 1'b0;
      if (start_at >= 0 && !sd_done && exp_k == start_at) begin
        start = 1'b1;
        sd_done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (dn_cnt == 0) chk("timeout", 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_tvalid", ax.tvalid, 1'b0);
    chk("beats", exp_k, DEPTH);
    chk("reads", rd_tot, DEPTH);
    chk("tlast_cnt", tl_cnt, 1);
    chk("done_cnt", dn_cnt, 1);
    chk("done_lat", dn_cyc - hsl_cyc, 1);
    chk("busy_at_done", busy_dn, 1'b0);
    if (mode == 0 && stall_at < 0) begin
      chk("first_tvalid_lat", tv_cyc - rd_cyc, 2);
      chk("tput", hsl_cyc - hs0_cyc, DEPTH - 1);
    end
    if (stall_at >= 0) chk("stall_reads_le3", st_rd <= 3, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ax.tready = 1'b0;
    reset_sb();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", ax.tvalid, 1'b0);
    chk("rst_tlast", ax.tlast, 1'b0);
    chk("rst_tdata", ax.tdata, 144'd0);
    chk("rst_tstrb", ax.tstrb, 18'd0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(0, -1, -1, -1);
    run_frame(0, 5, -1, -1);
    run_frame(1, -1, -1, -1);
    run_frame(0, -1, 100, -1);

    run_frame(0, -1, -1, 1000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_tvalid", ax.tvalid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_pixel_to_axis.md
BRAM_PIXEL_TO_AXIS -- requirements
Module: bram_pixel_to_axis

Interface
REQ-001 Parameter DATA_WIDTH, 16: width of one direction value.
REQ-002 Parameter DEPTH, 2500: pixels per frame.
REQ-003 Parameter ADDRESS_WIDTH, 12: width of the BRAM read address.
REQ-004 m00_axis_aclk  in  1: sole clock; all logic SHALL be rising-edge.
REQ-005 m00_axis_aresetn  in  1: reset, asynchronous assert, active-low.
REQ-006 start  in  1: one-cycle frame start request.
REQ-007 busy  out  1: high from frame acceptance until the final beat handshakes.
REQ-008 done  out  1: one-cycle pulse after the final beat.
REQ-009 rd_en  out  1: BRAM read strobe.
REQ-010 read_addr  out  ADDRESS_WIDTH: pixel address for the BRAM read.
REQ-011 n0, null0, ne0, e0, se0, s0, sw0, w0, nw0  in  16 each: BRAM read data, valid one cycle after rd_en.
REQ-012 m00_axis_tvalid  out  1: beat valid.
REQ-013 m00_axis_tdata  out  144: packed pixel.
REQ-014 m00_axis_tstrb  out  18: byte strobes.
REQ-015 m00_axis_tlast  out  1: last pixel of the frame.
REQ-016 m00_axis_tready  in  1: downstream ready.

Function
REQ-017 States: IDLE, STREAM, DRAIN, FINISH.
REQ-018 IDLE->STREAM on start=1, clearing read_addr and the beat counter.
REQ-019 STREAM->DRAIN when the read for pixel DEPTH-1 issues.
REQ-020 DRAIN->FINISH on the handshake of beat DEPTH-1.
REQ-021 FINISH->IDLE unconditionally; done=1 only in FINISH.
REQ-022 start while not in IDLE SHALL be ignored.
REQ-023 busy=1 in STREAM and DRAIN, 0 otherwise.
REQ-024 The block SHALL hold a 3-entry FIFO of 144-bit packed pixels plus an in-flight flag for the outstanding BRAM read.
REQ-025 rd_en=1 only in STREAM, and only when FIFO count + in-flight < 3; both values are sampled at cycle start, and a same-cycle pop is not counted.
REQ-026 read_addr increments by 1 after each rd_en cycle; it never exceeds DEPTH-1 while rd_en=1.
REQ-027 Read latency: data from rd_en in cycle N SHALL be written to the FIFO at the end of cycle N+1.
REQ-028 Packing: n0 -> [15:0], null0 -> [31:16], ne0 -> [47:32], e0 -> [63:48], se0 -> [79:64], s0 -> [95:80], sw0 -> [111:96], w0 -> [127:112], nw0 -> [143:128].
REQ-029 m00_axis_tvalid = FIFO not empty; tdata = FIFO head.
REQ-030 tstrb SHALL be all ones whenever tvalid=1.
REQ-031 Pop only on tvalid&&tready; a simultaneous push and pop SHALL leave the count unchanged.
REQ-032 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable; tvalid SHALL NOT drop before the handshake.
REQ-033 tlast=1 exactly on beat index DEPTH-1, counted by the 12-bit beat counter; tlast SHALL NOT assert on any other beat.
REQ-034 First tvalid: 2 cycles after the first rd_en.
REQ-035 With tready held at 1, the block SHALL sustain one beat per cycle.
REQ-036 tready toggling SHALL neither lose nor duplicate a pixel.
REQ-037 The FIFO SHALL never overflow; an overflow is a design error.

Reset
REQ-038 On aresetn=0, asynchronously: state=IDLE, FIFO empty, in-flight=0, read_addr=0, beat counter=0.
REQ-039 Outputs during reset: tvalid=0, tlast=0, tdata=0, tstrb=0, rd_en=0, busy=0, done=0.
REQ-040 Reset mid-frame SHALL abandon the frame; the next start SHALL restart from pixel 0.

Verification
REQ-041 BRAM model with pixel k, direction d = k*16+d, and tready=1; pulse start -> 2500 beats, beat k = packed {k*16+8..k*16+0}, tlast only on beat 2499, done one cycle after it, busy low with done.
REQ-042 Throughput, tready=1 -> beats 0..2499 on 2500 consecutive cycles; first tvalid 2 cycles after first rd_en.
REQ-043 tready=0 for 10 cycles from beat 5 -> tdata = beat 5 stable, tvalid=1 throughout, at most 3 reads past beat 5, then the stream resumes with no gap or duplicate.
REQ-044 Random 50% tready -> the scoreboard matches all 2500 beats in order; exactly one tlast.
REQ-045 start pulsed at beat 100 -> no effect; a single frame completes.
REQ-046 aresetn low at beat 1000 -> tvalid=0 immediately; a new start yields beat 0 = pixel 0 data.
